// File: rtl/ifu_fetch_buffer.sv
// Instruction fetch front end: sequential PC generation, in-order memory
// reads with bounded outstanding requests, and a {pc, instr} FIFO to ID.
module ifu_fetch_buffer #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_discard;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [31:0]     r_fifo_instr [DEPTH];

    logic          w_room;
    logic          w_slot_ok;
    logic          w_req_fire;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic [OW-1:0] w_owed;

    // Every issued request holds a FIFO slot until its response lands.
    assign w_room        = 32'(r_outst) < 32'(MAX_OUT);
    assign w_slot_ok     = (32'(r_count) + 32'(r_outst)) < 32'(DEPTH);
    assign mem_req_valid = rst & ~redirect_valid & ~halt & w_room & w_slot_ok;
    assign mem_req_addr  = r_fetch_pc;
    assign w_req_fire    = mem_req_valid & mem_req_ready;

    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_fifo_pc[r_rd_ptr] : '0;
    assign out_instr = out_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign w_pop     = out_valid & out_ready;

    assign w_drop = mem_resp_valid & (r_discard != '0);
    assign w_push = mem_resp_valid & (r_discard == '0) & ~redirect_valid;
    assign w_owed = r_outst - OW'(mem_resp_valid & (r_outst != '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            // Everything still owed by memory is now stale.
            r_fetch_pc <= redirect_pc;
            r_resp_pc  <= redirect_pc;
            r_outst    <= w_owed;
            r_discard  <= w_owed;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_outst <= r_outst + OW'(w_req_fire) - OW'(mem_resp_valid);
            if (w_drop) begin
                r_discard <= r_discard - OW'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + XLEN'(4);
                r_wr_ptr  <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
            r_fifo_instr[r_wr_ptr] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Scoreboard bench for ifu_fetch_buffer with a fixed-latency memory model.
module tb_ifu_fetch_buffer;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    typedef struct packed {
        logic [31:0] due;
        logic [63:0] addr;
    } mreq_t;

    mreq_t       mq[$];
    int          lat = 1;
    int unsigned cyc = 0;
    int          req_cnt = 0;
    logic        m_hs = 1'b0;
    logic [63:0] m_addr = '0;

    always #5 clk = ~clk;

    ifu_fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    function automatic logic [31:0] imem(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: request accepted at edge t is answered in the cycle
    // that ends at edge t+lat.
    always @(negedge clk) begin
        m_hs   = mem_req_valid && mem_req_ready;
        m_addr = mem_req_addr;
    end

    always @(posedge clk) begin : mem_model
        mreq_t e;
        cyc++;
        if (!rst) begin
            mq.delete();
            req_cnt = 0;
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
        end else begin
            if (m_hs) begin
                e.due  = cyc + 32'(lat);
                e.addr = m_addr;
                mq.push_back(e);
                req_cnt++;
            end
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                e = mq.pop_front();
                mem_resp_valid <= 1'b1;
                mem_resp_data  <= imem(e.addr);
            end else begin
                mem_resp_valid <= 1'b0;
            end
        end
    end

    // Monitor: every ID handshake must match the next expected entry.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc %h, nothing expected", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e);
                chk("out_instr", 64'(out_instr), 64'(imem(e)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic push_seq(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d left, expected 0", exp_q.size());
            exp_q.delete();
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        mem_req_ready  = 1'b1;
        out_ready      = 1'b0;

        // Reset state
        step();
        @(negedge clk);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        step();
        rst = 1'b1;

        // Streaming, 1-cycle memory: 2-cycle fill then one per cycle
        out_ready = 1'b1;
        push_seq(RST_PC, 8);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("p1_req_valid", 64'(mem_req_valid), 64'd1);
                chk("p1_req_addr", mem_req_addr, RST_PC);
            end
            chk("p1_out_valid", 64'(out_valid), 64'(c >= 2));
            step();
        end
        out_ready = 1'b0;
        chk("p1_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure: FIFO fills to DEPTH, then drains and refetches
        do_reset();
        push_seq(RST_PC, 8);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 7) begin
                chk("p2_req_stall", 64'(mem_req_valid), 64'd0);
                chk("p2_full_valid", 64'(out_valid), 64'd1);
                chk("p2_head_pc", out_pc, RST_PC);
                chk("p2_req_count", 64'(req_cnt), 64'd4);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("p2_req_still_off", 64'(mem_req_valid), 64'd0);
        step();
        @(negedge clk);
        chk("p2_resume_valid", 64'(mem_req_valid), 64'd1);
        chk("p2_resume_addr", mem_req_addr, RST_PC + 64'h10);
        step();
        drain(40);

        // Redirect with two stale requests in flight, 3-cycle memory
        lat = 3;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        push_seq(64'h8000_1000, 4);
        @(negedge clk);
        chk("p3_req_in_redir", 64'(mem_req_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        chk("p3_req_blocked", 64'(mem_req_valid), 64'd0);
        chk("p3_out_empty", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("p3_req_valid", 64'(mem_req_valid), 64'd1);
        chk("p3_req_addr", mem_req_addr, 64'h8000_1000);
        step();
        drain(40);

        // Redirect coinciding with a response and an ID handshake
        lat = 2;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 4) begin
                chk("p4_pre_valid", 64'(out_valid), 64'd1);
                chk("p4_pre_pc", out_pc, RST_PC);
            end
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        out_ready      = 1'b1;
        exp_q.push_back(RST_PC);
        push_seq(64'h8000_3000, 4);
        @(negedge clk);
        chk("p4_req_in_redir", 64'(mem_req_valid), 64'd0);
        chk("p4_resp_same_cyc", 64'(mem_resp_valid), 64'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("p4_req_valid", 64'(mem_req_valid), 64'd1);
        chk("p4_req_addr", mem_req_addr, 64'h8000_3000);
        chk("p4_out_flushed", 64'(out_valid), 64'd0);
        step();
        drain(40);

        // Halt with two requests outstanding
        lat = 3;
        do_reset();
        out_ready = 1'b1;
        push_seq(RST_PC, 4);
        step();
        step();
        halt = 1'b1;
        for (int c = 2; c < 8; c++) begin
            @(negedge clk);
            chk("p5_halt_no_req", 64'(mem_req_valid), 64'd0);
            if (c == 7) begin
                #1;
                chk("p5_delivered", 64'(exp_q.size()), 64'd2);
                chk("p5_req_count", 64'(req_cnt), 64'd2);
            end
            step();
        end
        halt = 1'b0;
        @(negedge clk);
        chk("p5_resume_valid", 64'(mem_req_valid), 64'd1);
        chk("p5_resume_addr", mem_req_addr, RST_PC + 64'h8);
        step();
        drain(40);

        // Reset mid-stream with a full FIFO
        lat = 1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 7) begin
                chk("p6_full_valid", 64'(out_valid), 64'd1);
                chk("p6_full_noreq", 64'(mem_req_valid), 64'd0);
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("p6_rst_req_gate", 64'(mem_req_valid), 64'd0);
        step();
        @(negedge clk);
        chk("p6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("p6_rst_out_pc", out_pc, 64'd0);
        chk("p6_rst_req_valid", 64'(mem_req_valid), 64'd0);
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        push_seq(RST_PC, 4);
        @(negedge clk);
        chk("p6_restart_valid", 64'(mem_req_valid), 64'd1);
        chk("p6_restart_addr", mem_req_addr, RST_PC);
        step();
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_buffer.md
# ifu_fetch_buffer

Instruction-fetch front end that sits directly upstream of the ID pipeline register. It generates sequential fetch PCs, issues in-order instruction reads over a variable-latency request/response memory port, and buffers returned instructions with their PCs in a small FIFO. The FIFO presents {pc, instr} to the ID stage over a valid/ready handshake. A redirect from ID/EX flushes the FIFO and discards responses still in flight.

## Interface
- XLEN, 64, PC/address width
- DEPTH, 4, instruction FIFO entries (power of two, ≥2)
- MAX_OUT, 2, maximum outstanding memory requests (1..DEPTH)
- RESET_PC, 64'h8000_0000, first fetch address after reset

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  one clock; reset is synchronous and active-low (rst=0 resets on the next clk edge)
- redirect_valid  in  1  taken branch/jump/trap; restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch address
- halt  in  1  stop issuing new requests (ebreak in flight); outstanding requests still complete
- mem_req_valid  out  1  read request
- mem_req_ready  in  1  memory accepts request when valid&ready
- mem_req_addr  out  XLEN  fetch address; always equals fetch_pc
- mem_resp_valid  in  1  instruction returned; in request order, at most one per cycle
- mem_resp_data  in  32  instruction word
- out_valid  out  1  FIFO head valid to ID
- out_ready  in  1  ID accepts head when valid&ready
- out_pc  out  XLEN  PC of head entry
- out_instr  out  32  instruction of head entry

## Operation
- State: fetch_pc, resp_pc (PC of next kept response), outstanding counter (0..MAX_OUT), discard counter (0..MAX_OUT), FIFO of DEPTH {pc, instr}, count.
- Issue rule: mem_req_valid = rst & ~redirect_valid & ~halt & (outstanding < MAX_OUT) & (count + outstanding < DEPTH), using registered values. This reserves a FIFO slot for every request, so a response is never dropped for lack of space.
- The memory side samples the request only on valid&ready. Valid may fall without a handshake (redirect/halt), and the address may change while valid is low.
- On a request handshake, fetch_pc += 4 and outstanding += 1.
- On a response, outstanding -= 1. If discard > 0, discard -= 1 and the data is dropped. Otherwise {resp_pc, data} is pushed to the FIFO and resp_pc += 4.
- Dequeue on out_valid & out_ready. Simultaneous push and pop leaves count unchanged.
- Redirect (priority over everything except reset):
  - FIFO cleared (count=0).
  - fetch_pc and resp_pc set to redirect_pc.
  - discard set to the number of responses still owed after this cycle, i.e. outstanding minus 1 if a response arrives in the same cycle. No request is issued that cycle.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle is still a valid ID handshake; the FIFO is cleared anyway.
- Redirect while discard > 0: discard is recomputed with the same rule. It covers all outstanding requests, since every one of them is stale.
- Halt does not flush. The FIFO keeps draining to ID.
- PC arithmetic wraps modulo 2^XLEN.

## Timing
- Reset values:
  - mem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
  - fetch_pc=resp_pc=RESET_PC; outstanding, discard and count are 0.
- First request is asserted in the first cycle with rst=1.
- A response accepted at edge t makes out_valid=1 in the cycle after t. There is no response-to-output bypass.
- Redirect asserted in cycle t:
  - out_valid=0 from cycle t+1.
  - mem_req_valid with mem_req_addr=redirect_pc in cycle t+1, provided outstanding < MAX_OUT.
- With single-cycle memory, mem_req_ready=1 and out_ready=1, steady state is one instruction per cycle.
- Reset mid-operation clears all state. The memory subsystem is reset by the same rst, so no stale responses return afterward.

## Test plan
- Reset release, memory ready every cycle, 1-cycle response latency, out_ready=1 -> requests at 0x80000000, 0x80000004, …; out_pc sequence matches with the correct instr; one output per cycle after a 2-cycle fill.
- out_ready=0 held -> exactly 4 entries accepted and mem_req_valid stays 0. Then out_ready=1 -> entries drain in order and fetch resumes at 0x80000010.
- 3-cycle response latency with 2 outstanding, redirect to 0x80001000 -> both stale responses dropped; the first out_pc after the redirect is 0x80001000.
- Redirect in the same cycle as a response and as an out handshake -> that response is dropped; discard equals the remaining outstanding count; no FIFO corruption.
- halt=1 with 2 outstanding -> no new requests; both responses are delivered to ID; fetch resumes on halt=0 at the next sequential PC.
- rst=0 asserted mid-stream with a full FIFO -> next cycle out_valid=0, mem_req_valid=0; after release, fetch restarts at 0x80000000.
